// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch unit.
//   fetch_state_t : fetch/label-pass FSM states
//   OP_STL/OP_BLT/OP_HLT : opcodes (instruction[7:4]) the decoder reacts to
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LBL_ISSUE = 3'd1,
    LBL_WAIT  = 3'd2,
    EXE_ISSUE = 3'd3,
    EXE_WAIT  = 3'd4,
    HALTED    = 3'd5
  } fetch_state_t;

  localparam logic [3:0] OP_STL = 4'b0111;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_HLT = 4'b1110;

endpackage

// File: rtl/instruction_fetch_if.sv
// -----------------------------------------------------------------------------
// instruction_fetch_if
// Bundles the instruction ROM port and the fetch <-> decoder signals.
//   master (fetch unit) drives : imem_addr, program_counter, instruction,
//                                label_pass
//   master receives            : imem_data, label_flag, label_value, label_idx,
//                                branch_flag, branch_taken, pc_reset_flag,
//                                halt_flag
//   slave is the mirror view (ROM + decoder side).
// -----------------------------------------------------------------------------
interface instruction_fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 8
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [PC_W-1:0]    program_counter;
  logic [INSTR_W-1:0] instruction;
  logic               label_pass;
  logic               label_flag;
  logic [PC_W-1:0]    label_value;
  logic [3:0]         label_idx;
  logic               branch_flag;
  logic               branch_taken;
  logic               pc_reset_flag;
  logic               halt_flag;

  modport master (
    output imem_addr, program_counter, instruction, label_pass,
    input  imem_data, label_flag, label_value, label_idx,
           branch_flag, branch_taken, pc_reset_flag, halt_flag
  );

  modport slave (
    input  imem_addr, program_counter, instruction, label_pass,
    output imem_data, label_flag, label_value, label_idx,
           branch_flag, branch_taken, pc_reset_flag, halt_flag
  );
endinterface

// File: rtl/instruction_fetch_label_table.sv
// -----------------------------------------------------------------------------
// label_table
// NUM_LABELS x PC_W label address register file, one write port and one
// combinational read port, asynchronously cleared by reset.
// Optional macro LABEL_CHECK_EN adds a valid bit per entry (set on write,
// cleared by reset or clear_valid); without it rd_valid is always 1.
//   clk, reset            : clock, async active-high reset
//   clear_valid           : drop all valid bits (new label pass)
//   wr_en/wr_idx/wr_data  : write port
//   rd_idx/rd_data        : combinational read port
//   rd_valid              : entry at rd_idx has been written
// -----------------------------------------------------------------------------
module label_table #(
  parameter int PC_W       = 8,
  parameter int NUM_LABELS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear_valid,
  input  logic            wr_en,
  input  logic [3:0]      wr_idx,
  input  logic [PC_W-1:0] wr_data,
  input  logic [3:0]      rd_idx,
  output logic [PC_W-1:0] rd_data,
  output logic            rd_valid
);

  logic [PC_W-1:0] entries [NUM_LABELS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LABELS; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_idx] <= wr_data;
    end
  end

  assign rd_data = entries[rd_idx];

`ifdef LABEL_CHECK_EN
  logic [NUM_LABELS-1:0] valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (clear_valid) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid[rd_idx];
`else
  logic unused_clear;
  assign unused_clear = clear_valid;
  assign rd_valid     = 1'b1;
`endif

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Program counter and fetch unit for the decoder. A start pulse runs a label
// pass (scan program, record stl addresses in the label table) followed by an
// execute pass (run program, blt targets resolved through the label table).
// Each instruction takes two clocks: ISSUE registers PC/instruction, WAIT
// samples the decoder flags produced from them.
// Optional macro LABEL_CHECK_EN: label valid bits; a taken branch to an
// unwritten label or a duplicate label write raises sticky label_err.
//   clk, reset : clock, async active-high reset
//   start      : one-cycle pulse, accepted in IDLE/HALTED only
//   bus        : ROM address/data and decoder signals (master modport)
//   busy       : label or execute pass in progress
//   done       : program halted
//   label_err  : label table misuse (0 unless LABEL_CHECK_EN)
// -----------------------------------------------------------------------------
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int PC_W       = 8,
  parameter int INSTR_W    = 8,
  parameter int NUM_LABELS = 16,
  parameter int LAST_PC    = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instruction_fetch_if.master bus,
  output logic                busy,
  output logic                done,
  output logic                label_err
);

  localparam logic [PC_W-1:0] LAST_ADDR = PC_W'(LAST_PC);

  fetch_state_t    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            issue;
  logic            start_go;
  logic            tbl_we;
  logic            err_set;
  logic [PC_W-1:0] tgt_pc;
  logic            tgt_valid;
  logic            take_branch;

  assign take_branch   = bus.branch_flag && bus.branch_taken;
  assign bus.imem_addr = pc_q;

  label_table #(
    .PC_W       (PC_W),
    .NUM_LABELS (NUM_LABELS)
  ) u_label_table (
    .clk         (clk),
    .reset       (reset),
    .clear_valid (start_go),
    .wr_en       (tbl_we),
    .wr_idx      (bus.label_idx),
    .wr_data     (bus.label_value),
    .rd_idx      (bus.label_idx),
    .rd_data     (tgt_pc),
    .rd_valid    (tgt_valid)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, HALTED: if (start) state_d = LBL_ISSUE;
      LBL_ISSUE:    state_d = LBL_WAIT;
      LBL_WAIT: begin
        // A label-pass hlt or running off the end of ROM both end the scan
        if (bus.pc_reset_flag || (pc_q == LAST_ADDR)) state_d = EXE_ISSUE;
        else                                          state_d = LBL_ISSUE;
      end
      EXE_ISSUE:    state_d = EXE_WAIT;
      EXE_WAIT: begin
        if (bus.halt_flag)                  state_d = HALTED;
        else if (take_branch && !tgt_valid) state_d = HALTED;
        else                                state_d = EXE_ISSUE;
      end
      default:      state_d = IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    bus.label_pass = 1'b0;
    issue          = 1'b0;
    start_go       = 1'b0;
    tbl_we         = 1'b0;
    err_set        = 1'b0;
    pc_d           = pc_q;
    case (state_q)
      IDLE, HALTED: begin
        done = (state_q == HALTED);
        if (start) begin
          start_go = 1'b1;
          pc_d     = '0;
        end
      end
      LBL_ISSUE: begin
        busy           = 1'b1;
        bus.label_pass = 1'b1;
        issue          = 1'b1;
      end
      LBL_WAIT: begin
        busy           = 1'b1;
        bus.label_pass = 1'b1;
        tbl_we         = bus.label_flag;
        // tgt_valid looks at the same slot being written: already valid = duplicate
        err_set        = bus.label_flag && tgt_valid;
        if (bus.pc_reset_flag || (pc_q == LAST_ADDR)) pc_d = '0;
        else                                          pc_d = pc_q + 1'b1;
      end
      EXE_ISSUE: begin
        busy  = 1'b1;
        issue = 1'b1;
      end
      EXE_WAIT: begin
        busy = 1'b1;
        if (bus.halt_flag) begin
          pc_d = pc_q;
        end else if (take_branch) begin
          if (tgt_valid) pc_d = tgt_pc;
          else           err_set = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Issue stage: PC and issued instruction held stable through WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q                <= '0;
      bus.program_counter <= '0;
      bus.instruction     <= '0;
    end else begin
      pc_q <= pc_d;
      if (issue) begin
        bus.program_counter <= pc_q;
        bus.instruction     <= bus.imem_data;
      end
    end
  end

`ifdef LABEL_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         label_err <= 1'b0;
    else if (start_go) label_err <= 1'b0;
    else if (err_set)  label_err <= 1'b1;
  end
`else
  logic unused_err;
  assign unused_err = err_set;
  assign label_err  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;
  import fetch_pkg::*;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] instr;
    logic       lp;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic taken;
  logic busy, done, label_err;
  logic [7:0] rom [256];

  int checks = 0;
  int errors = 0;
  exp_t exp_q [$];

  instruction_fetch_if #(.PC_W(8), .INSTR_W(8)) bus ();

  instruction_fetch #(
    .PC_W(8), .INSTR_W(8), .NUM_LABELS(16), .LAST_PC(255)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .label_err (label_err)
  );

  always #5 clk = ~clk;

  // ROM and a minimal decoder model working on the issued instruction
  assign bus.imem_data     = rom[bus.imem_addr];
  assign bus.label_flag    = bus.label_pass && (bus.instruction[7:4] == OP_STL);
  assign bus.label_value   = bus.program_counter;
  assign bus.label_idx     = bus.instruction[3:0];
  assign bus.branch_flag   = !bus.label_pass && (bus.instruction[7:4] == OP_BLT);
  assign bus.branch_taken  = taken;
  assign bus.pc_reset_flag = bus.label_pass && (bus.instruction[7:4] == OP_HLT);
  assign bus.halt_flag     = !bus.label_pass && (bus.instruction[7:4] == OP_HLT);

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every second busy cycle follows an issue edge
  logic in_wait = 1'b0;
  logic pending = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      in_wait = 1'b0;
      pending = 1'b0;
    end else begin
      if (pending) begin
        pending = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got pc %0h instr %0h lp %0b required none",
                   bus.program_counter, bus.instruction, bus.label_pass);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("issue_pc%0h", e.pc),
                {15'd0, bus.program_counter, bus.instruction, bus.label_pass},
                {15'd0, e.pc, e.instr, e.lp});
        end
      end
      if (busy && !in_wait) begin
        pending = 1'b1;
        in_wait = 1'b1;
      end else begin
        in_wait = 1'b0;
      end
    end
  end

  task automatic push_seq(int lo, int hi, logic lp);
    for (int p = lo; p <= hi; p++) begin
      exp_t e;
      e.pc    = 8'(p);
      e.instr = rom[p];
      e.lp    = lp;
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) break;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_drained(int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk); #2;
      if (exp_q.size() == 0) break;
    end
    check("queue_drained", exp_q.size(), 0);
  endtask

  // Hold branch_taken for the first execute-pass visit of pc only
  task automatic take_once(logic [7:0] pc);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.program_counter == pc && !bus.label_pass && busy) break;
    end
    @(posedge clk); #1;
    taken = 1'b0;
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_imem_addr"}, {24'd0, bus.imem_addr}, 32'd0);
    check({tag, "_pc"},        {24'd0, bus.program_counter}, 32'd0);
    check({tag, "_instr"},     {24'd0, bus.instruction}, 32'd0);
    check({tag, "_label_pass"}, {31'd0, bus.label_pass}, 32'd0);
    check({tag, "_busy"},      {31'd0, busy}, 32'd0);
    check({tag, "_done"},      {31'd0, done}, 32'd0);
    check({tag, "_label_err"}, {31'd0, label_err}, 32'd0);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < 256; a++) rom[a] = 8'h00;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    taken = 1'b0;
    clear_rom();
    #1;
    check_reset_outputs("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Label capture and halt: stl 5 at 3, hlt at 6
    rom[3] = 8'h75; rom[6] = 8'hE0;
    push_seq(0, 6, 1'b1);
    push_seq(0, 6, 1'b0);
    pulse_start();
    wait_done(200);
    check("halt_busy", {31'd0, busy}, 32'd0);
    check("halt_pc", {24'd0, bus.program_counter}, 32'd6);
    check("halt_imem_addr", {24'd0, bus.imem_addr}, 32'd6);
    check("halt_label_pass", {31'd0, bus.label_pass}, 32'd0);
    check("halt_queue", exp_q.size(), 0);

    // Branch not taken: blt 5 at 8 falls through to 9
    rom[6] = 8'h00; rom[8] = 8'h95; rom[12] = 8'hE0;
    taken = 1'b0;
    push_seq(0, 12, 1'b1);
    push_seq(0, 12, 1'b0);
    pulse_start();
    wait_done(300);
    check("nt_pc", {24'd0, bus.program_counter}, 32'd12);

    // Branch taken once: 8 -> table[5] = 3
    taken = 1'b1;
    push_seq(0, 12, 1'b1);
    push_seq(0, 8, 1'b0);
    push_seq(3, 12, 1'b0);
    pulse_start();
    take_once(8'd8);
    wait_done(300);
    check("tk_pc", {24'd0, bus.program_counter}, 32'd12);
    check("tk_label_err", {31'd0, label_err}, 32'd0);

    // Wrap: no hlt, label pass runs 0..255, start while busy is ignored
    clear_rom();
    rom[3] = 8'h75;
    push_seq(0, 255, 1'b1);
    push_seq(0, 4, 1'b0);
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    wait_drained(1200);
    check("wrap_busy", {31'd0, busy}, 32'd1);
    check("wrap_label_pass", {31'd0, bus.label_pass}, 32'd0);

    // Reset between edges in EXE_WAIT
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    reset = 1'b0;

    // table[5] cleared by reset: blt 5 at 2
    clear_rom();
    rom[2] = 8'h95; rom[4] = 8'hE0;
    taken = 1'b1;
    push_seq(0, 4, 1'b1);
`ifdef LABEL_CHECK_EN
    push_seq(0, 2, 1'b0);
    pulse_start();
    wait_done(200);
    taken = 1'b0;
    check("inv_label_err", {31'd0, label_err}, 32'd1);
    check("inv_pc", {24'd0, bus.imem_addr}, 32'd2);

    // Duplicate stl 5 at 1 and 3: error, last write (3) wins
    rom[1] = 8'h75; rom[3] = 8'h75;
    taken = 1'b1;
    push_seq(0, 4, 1'b1);
    push_seq(0, 2, 1'b0);
    push_seq(3, 4, 1'b0);
    pulse_start();
    take_once(8'd2);
    wait_done(200);
    check("dup_label_err", {31'd0, label_err}, 32'd1);
    check("dup_pc", {24'd0, bus.program_counter}, 32'd4);
`else
    push_seq(0, 2, 1'b0);
    push_seq(0, 4, 1'b0);
    pulse_start();
    take_once(8'd2);
    wait_done(200);
    check("clr_pc", {24'd0, bus.program_counter}, 32'd4);
    check("clr_label_err", {31'd0, label_err}, 32'd0);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
